// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID register and one-word skid buffer.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        fetch_misalign
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DROP,
`ifdef FETCH_ALIGN_CHK_EN
        S_HOLD,
        S_FAULT
`else
        S_HOLD
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_ifpc;
    logic [31:0] r_ifpc4;
    logic        r_misalign;

    logic [31:0] w_tgt;
    logic        w_deliver;
    logic [31:0] w_dinst;
    logic [31:0] w_dpc;

`ifdef FETCH_ALIGN_CHK_EN
    logic w_bad;
    assign w_bad = redirect & (|redirect_target[1:0]);
    assign w_tgt = redirect_target;
`else
    assign w_tgt = {redirect_target[31:2], redirect_target[1:0] & 2'b00};
`endif

    assign imem_req  = rst_n & (r_state == S_FETCH) & ~redirect & ~stall;
    assign imem_addr = r_pc;

    assign w_deliver = ~redirect & ~stall &
                       (((r_state == S_WAIT) & imem_ready) |
                        (r_state == S_HOLD));
    assign w_dinst = (r_state == S_HOLD) ? r_skid_inst : imem_rdata;
    assign w_dpc   = (r_state == S_HOLD) ? r_skid_pc : r_req_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_skid_inst <= NOP_INST;
            r_skid_pc   <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        r_pc <= w_tgt;
                    end else if (!stall) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pc    <= w_tgt;
                        r_state <= imem_ready ? S_FETCH : S_DROP;
                    end else if (imem_ready) begin
                        if (!stall) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_skid_inst <= imem_rdata;
                            r_skid_pc   <= r_req_pc;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                // Leave as soon as the orphaned response lands, even if
                // another redirect arrives with it.
                S_DROP: begin
                    if (redirect) r_pc <= w_tgt;
                    if (imem_ready) r_state <= S_FETCH;
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_tgt;
                        r_state <= S_FETCH;
                    end else if (!stall) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= r_state;
            endcase
`ifdef FETCH_ALIGN_CHK_EN
            if (w_bad) begin
                r_pc       <= r_pc;
                r_misalign <= 1'b1;
                r_state    <= S_FAULT;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_ifpc  <= 32'd0;
            r_ifpc4 <= 32'd4;
        end else if (redirect) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_deliver) begin
            r_valid <= 1'b1;
            r_inst  <= w_dinst;
            r_ifpc  <= w_dpc;
            r_ifpc4 <= w_dpc + 32'd4;
        end else begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end
    end

    assign if_id_valid    = r_valid;
    assign if_id_inst     = r_inst;
    assign if_id_pc       = r_ifpc;
    assign if_id_pc4      = r_ifpc4;
    assign fetch_misalign = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: one table row per clock cycle,
// plus hand sequences for the misaligned-redirect behaviour.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_misalign;

    int n_chk = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] data;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] einst;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic rd,
                       input logic [31:0] tgt, input logic rdy,
                       input logic [31:0] data, input logic ereq,
                       input logic [31:0] eaddr, input logic ev,
                       input logic [31:0] einst, input logic [31:0] epc);
        vec_t v;
        v.st = st; v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.data = data;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev;
        v.einst = einst; v.epc = epc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd,
                         input logic [31:0] tgt, input logic rdy,
                         input logic [31:0] data);
        stall = st; redirect = rd; redirect_target = tgt;
        imem_ready = rdy; imem_rdata = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        //   st rd tgt           rdy data          req addr          v inst          pc
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hA000_0000,0, 32'h0,        1, 32'hA000_0000,32'h0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hA000_0004,0, 32'h0,        1, 32'hA000_0004,32'h4);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hA000_0008,0, 32'h0,        1, 32'hA000_0008,32'h8);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hA000_0008,32'h8);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0, NOP,          0);
        add(1, 0, 32'h0,        1, 32'hA000_000C,0, 32'h0,        0, NOP,          0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hA000_000C,32'hC);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, NOP,          0);
        add(0, 1, 32'h100,      0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        1, BAD,          0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hB000_0100,0, 32'h0,        1, 32'hB000_0100,32'h100);
        add(1, 1, 32'h200,      0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      0, NOP,          0);
        add(0, 1, 32'h300,      1, BAD,          0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h300,      0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hC000_0300,0, 32'h0,        1, 32'hC000_0300,32'h300);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h304,      0, NOP,          0);
        add(1, 0, 32'h0,        1, BAD,          0, 32'h0,        0, NOP,          0);
        add(1, 1, 32'h400,      0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h400,      0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hD000_0400,0, 32'h0,        1, 32'hD000_0400,32'h400);
        add(0, 1, 32'hFFFF_FFFC,0, 32'h0,        0, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC,0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hE000_0000,0, 32'h0,        1, 32'hE000_0000,32'hFFFF_FFFC);
        add(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP,          0);
        add(0, 0, 32'h0,        1, 32'hE000_0001,0, 32'h0,        1, 32'hE000_0001,32'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_inst", if_id_inst, NOP);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h4);
        chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].tgt, tbl[i].rdy, tbl[i].data);
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req},
                {31'd0, tbl[i].ereq});
            if (tbl[i].ereq)
                chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid},
                {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_inst", i), if_id_inst, tbl[i].einst);
            chk($sformatf("v%0d_misalign", i), {31'd0, fetch_misalign}, 32'd0);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_pc", i), if_id_pc, tbl[i].epc);
                chk($sformatf("v%0d_pc4", i), if_id_pc4, tbl[i].epc + 32'd4);
            end
        end

`ifdef FETCH_ALIGN_CHK_EN
        drive(0, 1, 32'h102, 0, 0);
        #1;
        chk("mis_redir_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, (i == 2), 32'h200, (i == 1), BAD);
            #1;
            chk($sformatf("fault%0d_req", i), {31'd0, imem_req}, 32'd0);
            step();
            chk($sformatf("fault%0d_flag", i), {31'd0, fetch_misalign}, 32'd1);
            chk($sformatf("fault%0d_valid", i), {31'd0, if_id_valid}, 32'd0);
            chk($sformatf("fault%0d_inst", i), if_id_inst, NOP);
        end
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mis_clr", {31'd0, fetch_misalign}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
`else
        drive(0, 1, 32'h102, 0, 0);
        #1;
        chk("mis_redir_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd0);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("mis_req", {31'd0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h100);
        step();
        drive(0, 0, 0, 1, 32'hF000_0100);
        step();
        chk("mis_valid", {31'd0, if_id_valid}, 32'd1);
        chk("mis_inst", if_id_inst, 32'hF000_0100);
        chk("mis_pc", if_id_pc, 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
